// File: rtl/mac4_acc_pkg.sv
// Shared types and sizing constants for the 4x4 multiply-accumulate frame engine.
package mac4_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int MAX_BEATS = 16;
  localparam int ACC_W     = 12;
  localparam int CNT_W     = 5;

  // Zero-extend an 8-bit product to accumulator width.
  function automatic logic [ACC_W-1:0] prod_ext(input logic [7:0] p);
    return {{(ACC_W-8){1'b0}}, p};
  endfunction

endpackage

// File: rtl/mac4_acc_if.sv
// Operand/result handshake bundle between a producer/consumer (master) and mac4_acc (slave).
interface mac4_acc_if;
  import mac4_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output in_valid, a, b, in_last, out_ready,
    input  in_ready, out_valid, acc_out, beat_cnt
  );

  modport slave (
    input  in_valid, a, b, in_last, out_ready,
    output in_ready, out_valid, acc_out, beat_cnt
  );

endinterface

// File: rtl/mac4_acc_mul4.sv
// Unsigned 4x4 -> 8 bit combinational multiplier.
module mul4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  assign p_o = {4'b0000, a_i} * {4'b0000, b_i};

endmodule

// File: rtl/mac4_acc.sv
// Frame-based multiply-accumulate: sums a*b over up to MAX_BEATS beats, then holds the result
// until the consumer takes it.
module mac4_acc #(
  parameter int MAX_BEATS = mac4_pkg::MAX_BEATS
) (
  input  logic       clk,
  input  logic       rst,
  mac4_acc_if.slave  bus
);
  import mac4_pkg::*;

  state_e           state_q, state_d;
  logic [3:0]       op_a_q, op_a_d;
  logic [3:0]       op_b_q, op_b_d;
  logic             op_last_q, op_last_d;
  logic             op_vld_q, op_vld_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;

  logic             accept_s;
  logic             last_s;
  logic [CNT_W-1:0] beats_seen_s;
  logic [7:0]       prod_s;

  mul4 u_mul4 (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (prod_s)
  );

  assign accept_s     = bus.in_valid && (state_q == ACC);
  // The beat in the operand register has not reached cnt yet, so count it here.
  assign beats_seen_s = cnt_q + {{(CNT_W-1){1'b0}}, op_vld_q};
  assign last_s       = bus.in_last || (beats_seen_s == CNT_W'(MAX_BEATS - 1));

  assign bus.in_ready  = (state_q == ACC) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_q;
  assign bus.beat_cnt  = cnt_q;

  // Next-state logic for the sequencer, operand register and accumulator.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_last_d   = op_last_q;
    op_vld_d    = 1'b0;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;

    if (accept_s) begin
      op_a_d    = bus.a;
      op_b_d    = bus.b;
      op_last_d = last_s;
      op_vld_d  = 1'b1;
    end else begin
      op_vld_d  = 1'b0;
    end

    if (op_vld_q) begin
      acc_d = acc_q + prod_ext(prod_s);
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end

    case (state_q)
      ACC: begin
        if (accept_s && last_s) begin
          state_d = FLUSH;
        end else begin
          state_d = ACC;
        end
      end
      FLUSH: begin
        state_d     = DONE;
        out_valid_d = op_last_q;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = ACC;
          acc_d       = {ACC_W{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          out_valid_d = 1'b0;
        end else begin
          state_d     = DONE;
        end
      end
      default: begin
        state_d     = ACC;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      op_a_q      <= 4'd0;
      op_b_q      <= 4'd0;
      op_last_q   <= 1'b0;
      op_vld_q    <= 1'b0;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_last_q   <= op_last_d;
      op_vld_q    <= op_vld_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mac4_acc.sv
// Directed self-checking bench for mac4_acc with hand-computed frame results.
module tb_mac4_acc;

  logic clk;
  logic rst;
  int   checks_q;
  int   failures_q;

  mac4_acc_if bus ();

  mac4_acc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_q++;
    if (got !== exp) begin
      failures_q++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] av, input logic [3:0] bv, input logic lst);
    chk("in_ready_before_beat", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.in_last  = lst;
    step();
    bus.in_valid = 1'b0;
    bus.a        = 4'd0;
    bus.b        = 4'd0;
    bus.in_last  = 1'b0;
  endtask

  // Called in cycle c+1 after the last beat was accepted in cycle c.
  task automatic expect_done(input logic [11:0] exp_acc, input logic [4:0] exp_cnt);
    chk("out_valid_c1", 32'(bus.out_valid), 32'd0);
    chk("in_ready_flush", 32'(bus.in_ready), 32'd0);
    step();
    chk("out_valid_c2", 32'(bus.out_valid), 32'd1);
    chk("acc_out", 32'(bus.acc_out), 32'(exp_acc));
    chk("beat_cnt", 32'(bus.beat_cnt), 32'(exp_cnt));
    chk("in_ready_done", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("in_ready_after_release", 32'(bus.in_ready), 32'd1);
    chk("out_valid_after_release", 32'(bus.out_valid), 32'd0);
    chk("acc_cleared", 32'(bus.acc_out), 32'd0);
    chk("cnt_cleared", 32'(bus.beat_cnt), 32'd0);
  endtask

  initial begin
    checks_q      = 0;
    failures_q    = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 4'd0;
    bus.b         = 4'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_acc", 32'(bus.acc_out), 32'd0);
    chk("rst_cnt", 32'(bus.beat_cnt), 32'd0);
    rst = 1'b0;
    #1;

    // Single maximal beat, first cycle after reset.
    send(4'd15, 4'd15, 1'b1);
    expect_done(12'd225, 5'd1);
    release_result();

    // Back-to-back three-beat frame: 12 + 30 + 56.
    send(4'd3, 4'd4, 1'b0);
    send(4'd5, 4'd6, 1'b0);
    send(4'd7, 4'd8, 1'b1);
    expect_done(12'd98, 5'd3);
    release_result();

    // Same frame with 2-cycle bubbles; out_ready pulsed outside DONE must be ignored.
    send(4'd3, 4'd4, 1'b0);
    bus.out_ready = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    chk("gap_acc", 32'(bus.acc_out), 32'd12);
    chk("gap_cnt", 32'(bus.beat_cnt), 32'd1);
    send(4'd5, 4'd6, 1'b0);
    step();
    step();
    chk("gap2_acc", 32'(bus.acc_out), 32'd42);
    chk("gap2_cnt", 32'(bus.beat_cnt), 32'd2);
    send(4'd7, 4'd8, 1'b1);
    expect_done(12'd98, 5'd3);
    release_result();

    // 16 beats without in_last: forced end of frame.
    for (int i = 0; i < 16; i++) begin
      send(4'd15, 4'd15, 1'b0);
    end
    expect_done(12'd3600, 5'd16);

    // Hold in DONE with in_valid asserted: result must stay put.
    bus.in_valid = 1'b1;
    bus.a        = 4'd15;
    bus.b        = 4'd15;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_acc", 32'(bus.acc_out), 32'd3600);
      chk("hold_cnt", 32'(bus.beat_cnt), 32'd16);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.a        = 4'd0;
    bus.b        = 4'd0;
    release_result();
    send(4'd2, 4'd3, 1'b1);
    expect_done(12'd6, 5'd1);
    release_result();

    // Reset mid-frame after two beats discards the partial sum.
    send(4'd9, 4'd9, 1'b0);
    send(4'd8, 4'd8, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_acc", 32'(bus.acc_out), 32'd0);
    chk("midrst_cnt", 32'(bus.beat_cnt), 32'd0);
    step();
    chk("midrst_acc_held", 32'(bus.acc_out), 32'd0);
    rst = 1'b0;
    #1;
    send(4'd2, 4'd3, 1'b1);
    expect_done(12'd6, 5'd1);
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
    $finish;
  end

endmodule
